zbt_sram_model: RTL

Parametrised behavioural model of a pipelined ZBT SRAM for memory-interface testbenches, replacing the fixed 2-cycle model.
- Adds configurable word/address width, configurable read/write latency, per-byte write enables, a clock-enable stall and explicit read-valid and write-acknowledge strobes.
- Sits under the memory interface in simulation, exactly where the physical ZBT chip sits on hardware.

---
 rtl/zbt_sram_model.sv | 123 ++++++++++++
 1 files changed

// File: rtl/zbt_sram_model.sv
// zbt_sram_model
//   Parametrised behavioural model of a pipelined ZBT SRAM. A command is
//   sampled on one rising edge of clock. It completes LATENCY-1 enabled edges
//   later. Commands complete strictly in issue order, one per enabled edge.
//   A read and a write both complete in the final stage, so a read always
//   sees every write that completed before it, with no forwarding logic.
//
// Ports
//   clock    : system clock, all activity on the rising edge
//   reset    : synchronous, active-high; has priority over cen
//   cen      : clock enable; 0 freezes the model (strobes drop to 0)
//   req      : 1 = issue a command on this edge, 0 = bubble
//   wr       : 1 = write, 0 = read (qualified by req)
//   addr     : word address
//   write    : write data
//   byte_en  : per-lane write enable, bit i covers [i*BYTE_W +: BYTE_W]
//   data     : read result, or the merged word for a write
//   rd_valid : one-cycle strobe, data holds a read result
//   wr_ack   : one-cycle strobe, a write committed on the last edge
module zbt_sram_model #(
  parameter int DATA_W         = 36,
  parameter int BYTE_W         = 9,
  parameter int ADDR_W         = 10,
  parameter int LATENCY        = 2,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = DATA_W / BYTE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cen,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write,
  input  logic [NB-1:0]     byte_en,
  output logic [DATA_W-1:0] data,
  output logic              rd_valid,
  output logic              wr_ack
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $fatal(1, "zbt_sram_model: LATENCY must be in 1..4");
  end
  if (DATA_W % BYTE_W != 0) begin : g_bad_width
    $fatal(1, "zbt_sram_model: DATA_W must be a multiple of BYTE_W");
  end

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  // Registered stages ahead of the final one. With LATENCY = 1 the incoming
  // command is itself the final stage, and the single register is unused.
  localparam int unsigned PIPE_D = (LATENCY > 1) ? LATENCY - 1 : 1;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     be;
  } op_t;

  logic [DATA_W-1:0] mem [DEPTH];
  op_t               pipe [PIPE_D];
  op_t               cmd_in;
  op_t               fin;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;

  always_comb begin
    cmd_in       = '0;
    cmd_in.valid = req;
    cmd_in.wr    = wr;
    cmd_in.addr  = addr;
    cmd_in.wdata = write;
    cmd_in.be    = byte_en;

    fin = (LATENCY == 1) ? cmd_in : pipe[PIPE_D-1];

    old_word = mem[fin.addr];
    merged   = old_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (fin.be[i]) begin
        merged[i*BYTE_W +: BYTE_W] = fin.wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE_D; i++) begin
        pipe[i] <= '0;
      end
      data     <= '0;
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      if (CLEAR_ON_RESET != 0) begin
        for (int unsigned w = 0; w < DEPTH; w++) begin
          mem[w] <= '0;
        end
      end
    end else if (cen) begin
      pipe[0] <= cmd_in;
      for (int unsigned i = 1; i < PIPE_D; i++) begin
        pipe[i] <= pipe[i-1];
      end
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      if (fin.valid) begin
        if (fin.wr) begin
          mem[fin.addr] <= merged;
          data          <= merged;
          wr_ack        <= 1'b1;
        end else begin
          data     <= old_word;
          rd_valid <= 1'b1;
        end
      end
    end else begin
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
    end
  end

endmodule
